multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL use one parameter: MEM_HANDSHAKE, default 1, where 1 means memory states wait for MemReady and 0 means every memory state completes in one cycle with MemReady ignored.
REQ-002 The block SHALL use one clock and one reset; reset is synchronous and active-low.
REQ-003 Ports (name  direction  width  meaning):
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous active-low reset.
- OpCode  in  6  opcode field from the instruction register.
- MemReady  in  1  memory access complete this cycle.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IorD  out  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  PC load qualified externally by Zero.
- PCSrc  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = funct field.
- RegWrite  out  1  register file write.
- RegDest  out  1  destination register: 0 = rt, 1 = rd.
- MemtoReg  out  1  write-back source: 0 = ALUOut, 1 = memory data.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
- State  out  4  current state encoding, for debug.

Function
REQ-004 The state machine SHALL use these states and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11; encodings 12-15 SHALL go to FETCH on the next edge.
- In encodings 12-15 every control output SHALL be 0.
REQ-005 FETCH SHALL drive MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 00.
- IRWrite and PCWrite SHALL be asserted only in the cycle MemReady = 1, or in every FETCH cycle when MEM_HANDSHAKE = 0.
- The block SHALL stay in FETCH until that cycle, then go to DECODE.
REQ-006 DECODE SHALL drive ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00, then branch on OpCode:
- 100011 (lw) and 101011 (sw) -> MEMADR.
- 000000 (R-type) -> EXEC.
- 000100 (beq) -> BRANCH.
- 001000 (addi) -> ADDIEX.
- 000010 (j) -> JUMP.
- any other opcode -> FETCH, with IllegalOp = 1 for that DECODE cycle only.
REQ-007 MEMADR SHALL drive ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00, then go to MEMRD for lw or MEMWR for sw.
- OpCode SHALL be re-sampled here; the instruction register holds it stable.
REQ-008 MEMRD SHALL drive MemRead = 1 and IorD = 1, and SHALL wait for MemReady (handshake as in FETCH), then go to MEMWB.
REQ-009 MEMWB SHALL drive RegWrite = 1, RegDest = 0, MemtoReg = 1, then go to FETCH.
REQ-010 MEMWR SHALL drive MemWrite = 1 and IorD = 1, hold both until MemReady, then go to FETCH.
REQ-011 EXEC SHALL drive ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10, then go to ALUWB.
REQ-012 ALUWB SHALL drive RegWrite = 1, RegDest = 1, MemtoReg = 0, then go to FETCH.
REQ-013 BRANCH SHALL drive ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, Branch = 1, PCSrc = 01, then go to FETCH.
REQ-014 ADDIEX SHALL drive ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00, then go to ADDIWB.
REQ-015 ADDIWB SHALL drive RegWrite = 1, RegDest = 0, MemtoReg = 0, then go to FETCH.
REQ-016 JUMP SHALL drive PCWrite = 1 and PCSrc = 10, then go to FETCH.
REQ-017 Any output not listed for a state SHALL be 0 in that state.
- MemRead and MemWrite SHALL never be high in the same cycle.
- RegWrite and a memory request SHALL never be high in the same cycle.
REQ-018 With MemReady held at 1, instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Each memory wait cycle SHALL add exactly one cycle.
REQ-019 The block SHALL not time out; it waits for MemReady indefinitely.
- A MemReady pulse outside FETCH, MEMRD or MEMWR SHALL be ignored.

Reset
REQ-020 While RST = 0 at a rising edge, the state SHALL become FETCH.
REQ-021 During reset every control output, including IllegalOp, SHALL be forced to 0, and State SHALL read 0.
REQ-022 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction without any further PCWrite, RegWrite or MemWrite.
REQ-023 The first FETCH after reset is released SHALL behave normally.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release, OpCode = 100011, MemReady = 1 -> State 0, 1, 2, 3, 4, 0; RegWrite = 1 and MemtoReg = 1 only in state 4.
- sw with MemReady low for 3 cycles in MEMWR -> MemWrite = 1 and IorD = 1 held 4 cycles; exit to FETCH on the MemReady edge.
- R-type then beq back to back -> ALUOp = 10 in EXEC, then ALUOp = 01 and Branch = 1 in BRANCH; total 7 cycles.
- OpCode = 111111 in DECODE -> IllegalOp = 1 for one cycle; FETCH next; no RegWrite or MemWrite.
- RST = 0 during a MEMRD wait -> State 0 on the next edge with all outputs 0; the next fetch completes normally.
- MEM_HANDSHAKE = 0 with MemReady tied to 0 -> lw completes in 5 cycles.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style datapath controller.
// Sequences fetch, decode, memory, execute and write-back states and decodes
// the datapath control word from the current state.
//
// Parameter:
//   MEM_HANDSHAKE  1: memory states wait for MemReady; 0: memory states take one cycle
// Ports:
//   CLK, RST       clock (rising edge), synchronous active-low reset
//   OpCode[5:0]    opcode field from the instruction register
//   MemReady       memory access completes this cycle
//   MemRead, MemWrite, IorD                     memory request and address select
//   IRWrite, PCWrite, Branch, PCSrc[1:0]        instruction register / PC control
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]           ALU operand and operation select
//   RegWrite, RegDest, MemtoReg                 register file write-back control
//   IllegalOp      one-cycle pulse on an unsupported opcode in DECODE
//   State[3:0]     current state encoding (debug)
module multi_cycle_control #(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OpCode,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       RegDest,
  output logic       MemtoReg,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t state;

  // Memory access completes this cycle (always true without handshake).
  logic ready_c;
  assign ready_c = (MEM_HANDSHAKE == 32'd0) || MemReady;

  // State register with next-state selection.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  if (ready_c) state <= DECODE;
        DECODE: begin
          case (OpCode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXEC;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        // OpCode is held by the instruction register, so re-sampling is safe.
        MEMADR: begin
          if (OpCode == OP_LW)      state <= MEMRD;
          else if (OpCode == OP_SW) state <= MEMWR;
          else                      state <= FETCH;
        end
        MEMRD:  if (ready_c) state <= MEMWB;
        MEMWR:  if (ready_c) state <= FETCH;
        EXEC:   state <= ALUWB;
        ADDIEX: state <= ADDIWB;
        MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Control word decode; reset held low forces every output to zero so an
  // abandoned instruction cannot issue a write in the reset cycle.
  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    PCSrc     = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    RegDest   = 1'b0;
    MemtoReg  = 1'b0;
    IllegalOp = 1'b0;
    State     = 4'd0;
    if (RST) begin
      State = 4'(state);
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = ready_c;
          PCWrite = ready_c;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (OpCode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: IllegalOp = 1'b0;
            default: IllegalOp = 1'b1;
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          RegDest  = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          Branch  = 1'b1;
          PCSrc   = 2'b01;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDIWB: begin
          RegWrite = 1'b1;
        end
        JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end
        default: begin
          State = 4'(state);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed instruction sequences
// push per-cycle expected state/control words; a negedge monitor pops and
// compares them against a handshake instance and a no-handshake instance.
module tb_multi_cycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       rdy;

  logic       mr_a, mw_a, iord_a, irw_a, pcw_a, br_a, asa_a, rw_a, rd_a, m2r_a, ill_a;
  logic [1:0] pcs_a, asb_a, aop_a;
  logic [3:0] st_a;
  logic       mr_b, mw_b, iord_b, irw_b, pcw_b, br_b, asa_b, rw_b, rd_b, m2r_b, ill_b;
  logic [1:0] pcs_b, asb_b, aop_b;
  logic [3:0] st_b;

  multi_cycle_control #(.MEM_HANDSHAKE(1)) dut (
    .CLK(clk), .RST(rst), .OpCode(op), .MemReady(rdy),
    .MemRead(mr_a), .MemWrite(mw_a), .IorD(iord_a), .IRWrite(irw_a),
    .PCWrite(pcw_a), .Branch(br_a), .PCSrc(pcs_a), .ALUSrcA(asa_a),
    .ALUSrcB(asb_a), .ALUOp(aop_a), .RegWrite(rw_a), .RegDest(rd_a),
    .MemtoReg(m2r_a), .IllegalOp(ill_a), .State(st_a)
  );

  multi_cycle_control #(.MEM_HANDSHAKE(0)) dut_nohs (
    .CLK(clk), .RST(rst), .OpCode(op), .MemReady(1'b0),
    .MemRead(mr_b), .MemWrite(mw_b), .IorD(iord_b), .IRWrite(irw_b),
    .PCWrite(pcw_b), .Branch(br_b), .PCSrc(pcs_b), .ALUSrcA(asa_b),
    .ALUSrcB(asb_b), .ALUOp(aop_b), .RegWrite(rw_b), .RegDest(rd_b),
    .MemtoReg(m2r_b), .IllegalOp(ill_b), .State(st_b)
  );

  logic [16:0] ctl_a, ctl_b;
  assign ctl_a = {mr_a, mw_a, iord_a, irw_a, pcw_a, br_a, pcs_a, asa_a, asb_a, aop_a,
                  rw_a, rd_a, m2r_a, ill_a};
  assign ctl_b = {mr_b, mw_b, iord_b, irw_b, pcw_b, br_b, pcs_b, asa_b, asb_b, aop_b,
                  rw_b, rd_b, m2r_b, ill_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        chk2;
    logic [3:0]  st2;
    logic [16:0] ctl2;
  } exp_t;

  exp_t  q[$];
  int    total = 0;
  int    bad   = 0;
  int    ncyc  = 0;
  string scen  = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // {MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
  //  RegWrite, RegDest, MemtoReg, IllegalOp}
  function automatic logic [16:0] cv(
    input logic mr, input logic mw, input logic iord, input logic irw, input logic pcw,
    input logic br, input logic [1:0] pcs, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic rw, input logic rd, input logic m2r, input logic ill);
    return {mr, mw, iord, irw, pcw, br, pcs, asa, asb, aop, rw, rd, m2r, ill};
  endfunction

  logic [16:0] ZERO, F_RDY, F_WAIT, DEC, DEC_ILL, MADR, MRD, MWB, MWR, EXE, AWB, BR, AIEX, AIWB, JMP;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         ADDI = 6'b001000, JOP = 6'b000010, BADOP = 6'b111111;

  // Monitor: compare popped expectations away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("%s.%0d.state", scen, ncyc), 32'(st_a), 32'(e.st));
      check($sformatf("%s.%0d.ctl", scen, ncyc), 32'(ctl_a), 32'(e.ctl));
      check($sformatf("%s.%0d.excl", scen, ncyc),
            32'({mr_a & mw_a, rw_a & (mr_a | mw_a)}), 32'd0);
      if (e.chk2) begin
        check($sformatf("%s.%0d.state_nohs", scen, ncyc), 32'(st_b), 32'(e.st2));
        check($sformatf("%s.%0d.ctl_nohs", scen, ncyc), 32'(ctl_b), 32'(e.ctl2));
      end
    end
  end

  task automatic step2(input logic r, input logic [5:0] o, input logic m,
                       input logic [3:0] st, input logic [16:0] c,
                       input logic chk2, input logic [3:0] st2, input logic [16:0] c2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    op  = o;
    rdy = m;
    ncyc++;
    e.st = st; e.ctl = c; e.chk2 = chk2; e.st2 = st2; e.ctl2 = c2;
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic m,
                      input logic [3:0] st, input logic [16:0] c);
    step2(r, o, m, st, c, 1'b0, 4'd0, 17'd0);
  endtask

  initial begin
    rst = 1'b0;
    op  = LW;
    rdy = 1'b1;
    ZERO    = 17'd0;
    F_RDY   = cv(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0);
    F_WAIT  = cv(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0);
    DEC     = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0);
    DEC_ILL = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b1);
    MADR    = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0);
    MRD     = cv(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0);
    MWB     = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0);
    MWR     = cv(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0);
    EXE     = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0);
    AWB     = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b1,1'b0,1'b0);
    BR      = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0);
    AIEX    = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0);
    AIWB    = cv(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0);
    JMP     = cv(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0);

    // Reset, then lw with MemReady high: 0,1,2,3,4,0.
    scen = "lw";
    step(1'b0, LW, 1'b1, 4'd0, ZERO);
    step(1'b0, LW, 1'b1, 4'd0, ZERO);
    step(1'b1, LW, 1'b1, 4'd0, F_RDY);
    step(1'b1, LW, 1'b1, 4'd1, DEC);
    step(1'b1, LW, 1'b1, 4'd2, MADR);
    step(1'b1, LW, 1'b1, 4'd3, MRD);
    step(1'b1, LW, 1'b1, 4'd4, MWB);

    // sw with three wait cycles in MEMWR.
    scen = "sw";
    step(1'b1, SW, 1'b1, 4'd0, F_RDY);
    step(1'b1, SW, 1'b0, 4'd1, DEC);
    step(1'b1, SW, 1'b1, 4'd2, MADR);
    step(1'b1, SW, 1'b0, 4'd5, MWR);
    step(1'b1, SW, 1'b0, 4'd5, MWR);
    step(1'b1, SW, 1'b0, 4'd5, MWR);
    step(1'b1, SW, 1'b1, 4'd5, MWR);

    // R-type then beq back to back; stray MemReady in EXEC/DECODE ignored.
    scen = "rt_beq";
    step(1'b1, RT, 1'b1, 4'd0, F_RDY);
    step(1'b1, RT, 1'b1, 4'd1, DEC);
    step(1'b1, RT, 1'b1, 4'd6, EXE);
    step(1'b1, RT, 1'b0, 4'd7, AWB);
    step(1'b1, BEQ, 1'b1, 4'd0, F_RDY);
    step(1'b1, BEQ, 1'b1, 4'd1, DEC);
    step(1'b1, BEQ, 1'b1, 4'd8, BR);

    // addi with one fetch wait cycle, then j.
    scen = "addi_j";
    step(1'b1, ADDI, 1'b0, 4'd0, F_WAIT);
    step(1'b1, ADDI, 1'b1, 4'd0, F_RDY);
    step(1'b1, ADDI, 1'b0, 4'd1, DEC);
    step(1'b1, ADDI, 1'b1, 4'd9, AIEX);
    step(1'b1, ADDI, 1'b1, 4'd10, AIWB);
    step(1'b1, JOP, 1'b1, 4'd0, F_RDY);
    step(1'b1, JOP, 1'b1, 4'd1, DEC);
    step(1'b1, JOP, 1'b1, 4'd11, JMP);

    // Illegal opcode: one-cycle pulse then FETCH.
    scen = "illegal";
    step(1'b1, BADOP, 1'b1, 4'd0, F_RDY);
    step(1'b1, BADOP, 1'b1, 4'd1, DEC_ILL);
    step(1'b1, BADOP, 1'b0, 4'd0, F_WAIT);

    // Reset during a MEMRD wait, then a clean lw.
    scen = "rst_memrd";
    step(1'b1, LW, 1'b1, 4'd0, F_RDY);
    step(1'b1, LW, 1'b1, 4'd1, DEC);
    step(1'b1, LW, 1'b0, 4'd2, MADR);
    step(1'b1, LW, 1'b0, 4'd3, MRD);
    step(1'b0, LW, 1'b0, 4'd0, ZERO);
    step(1'b0, LW, 1'b0, 4'd0, ZERO);
    step(1'b1, LW, 1'b1, 4'd0, F_RDY);
    step(1'b1, LW, 1'b1, 4'd1, DEC);
    step(1'b1, LW, 1'b1, 4'd2, MADR);
    step(1'b1, LW, 1'b1, 4'd3, MRD);
    step(1'b1, LW, 1'b1, 4'd4, MWB);

    // No-handshake instance: lw in 5 cycles with MemReady tied low, while
    // the handshake instance stalls in FETCH on the same low MemReady.
    scen = "nohs";
    step2(1'b0, LW, 1'b0, 4'd0, ZERO,   1'b1, 4'd0, ZERO);
    step2(1'b1, LW, 1'b0, 4'd0, F_WAIT, 1'b1, 4'd0, F_RDY);
    step2(1'b1, LW, 1'b0, 4'd0, F_WAIT, 1'b1, 4'd1, DEC);
    step2(1'b1, LW, 1'b0, 4'd0, F_WAIT, 1'b1, 4'd2, MADR);
    step2(1'b1, LW, 1'b0, 4'd0, F_WAIT, 1'b1, 4'd3, MRD);
    step2(1'b1, LW, 1'b0, 4'd0, F_WAIT, 1'b1, 4'd4, MWB);
    step2(1'b1, LW, 1'b0, 4'd0, F_WAIT, 1'b1, 4'd0, F_RDY);

    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
